// File: rtl/kgp_ctrl_pkg.sv
// KGP-RISC multi-cycle control: opcodes, state/class encodings, datapath select codes.
package kgp_ctrl_pkg;

    localparam int unsigned OP_W    = 6;
    localparam int unsigned ALUOP_W = 3;
    localparam int unsigned PCSRC_W = 2;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BR    = 6'b000100;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;
    localparam logic [OP_W-1:0] OP_HALT  = 6'b111111;

    // RTYPE defers the ALU function to the instruction's funct field.
    localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 3'b000;
    localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 3'b001;
    localparam logic [ALUOP_W-1:0] ALUOP_FUNCT = 3'b111;

    localparam logic [PCSRC_W-1:0] PC_SRC_SEQ = 2'b00;
    localparam logic [PCSRC_W-1:0] PC_SRC_BR  = 2'b01;
    localparam logic [PCSRC_W-1:0] PC_SRC_JMP = 2'b10;

    localparam logic WB_SEL_ALU   = 1'b0;
    localparam logic WB_SEL_MEM   = 1'b1;
    localparam logic ADDR_SEL_PC  = 1'b0;
    localparam logic ADDR_SEL_ALU = 1'b1;
    localparam logic ALU_SRC_REG  = 1'b0;
    localparam logic ALU_SRC_IMM  = 1'b1;

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_FETCH      = 4'd1,
        ST_FETCH_DONE = 4'd2,
        ST_DECODE     = 4'd3,
        ST_EXEC       = 4'd4,
        ST_MEM        = 4'd5,
        ST_WB         = 4'd6,
        ST_HALT       = 4'd7,
        ST_TRAP       = 4'd8
    } state_e;

    typedef enum logic [3:0] {
        CLS_NONE  = 4'd0,
        CLS_RTYPE = 4'd1,
        CLS_ADDI  = 4'd2,
        CLS_LW    = 4'd3,
        CLS_SW    = 4'd4,
        CLS_BR    = 4'd5,
        CLS_J     = 4'd6,
        CLS_HALT  = 4'd7,
        CLS_ILL   = 4'd8
    } op_class_e;

    // Datapath strobes held in one register bank.
    typedef struct packed {
        logic               mem_rd;
        logic               mem_wr;
        logic               addr_sel;
        logic               ir_we;
        logic               pc_we;
        logic [PCSRC_W-1:0] pc_src;
        logic [ALUOP_W-1:0] aluop;
        logic               alu_src;
        logic               reg_we;
        logic               wb_sel;
        logic               busy;
    } ctrl_out_t;

    // Map the IR opcode field to an instruction class.
    function automatic op_class_e decode_op(input logic [OP_W-1:0] op);
        op_class_e cls;
        case (op)
            OP_RTYPE: cls = CLS_RTYPE;
            OP_ADDI:  cls = CLS_ADDI;
            OP_LW:    cls = CLS_LW;
            OP_SW:    cls = CLS_SW;
            OP_BR:    cls = CLS_BR;
            OP_J:     cls = CLS_J;
            OP_HALT:  cls = CLS_HALT;
            default:  cls = CLS_ILL;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/kgp_mem_wait_timer.sv
// Memory wait counter: counts un-acknowledged request cycles and flags the
// cycle in which the TIMEOUT-th un-acknowledged cycle would occur.
// TIMEOUT = 0 disables expiry.
module kgp_mem_wait_timer #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam bit          TO_EN = (TIMEOUT != 0);
    localparam int unsigned LIM   = TO_EN ? (TIMEOUT - 1) : 0;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             exp_q, exp_d;

    // Next count; expiry flag is precomputed so the current request cycle sees it registered.
    always_comb begin
        cnt_d = cnt_q;
        exp_d = exp_q;
        if (clr_i) begin
            cnt_d = '0;
            exp_d = TO_EN && (LIM == 0);
        end else if (en_i) begin
            cnt_d = cnt_q + CNT_W'(1);
            exp_d = TO_EN && (cnt_d == CNT_W'(LIM));
        end
    end

    // Counter and flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            exp_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            exp_q <= exp_d;
        end
    end

    assign expired_o = exp_q;

endmodule

// File: rtl/kgp_multicycle_ctrl.sv
// KGP-RISC multi-cycle control FSM: sequences fetch/decode/execute/memory/
// writeback and drives datapath strobes, handshaking with a single memory port.
// Optional `KGP_PERF_CNT_EN adds cycle and retired-instruction counters.
module kgp_multicycle_ctrl
    import kgp_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned CNT_W       = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run_i,
    input  logic [OP_W-1:0]    op_i,
    input  logic               br_taken_i,
    input  logic               mem_ack_i,
    output logic               mem_rd_o,
    output logic               mem_wr_o,
    output logic               addr_sel_o,
    output logic               ir_we_o,
    output logic               pc_we_o,
    output logic [PCSRC_W-1:0] pc_src_o,
    output logic [ALUOP_W-1:0] aluop_o,
    output logic               alu_src_o,
    output logic               reg_we_o,
    output logic               wb_sel_o,
    output logic               busy_o,
    output logic               halted_o,
    output logic               illegal_o,
    output logic               mem_err_o
`ifdef KGP_PERF_CNT_EN
    ,
    output logic [31:0]        cyc_cnt_o,
    output logic [31:0]        ret_cnt_o
`endif
);

    state_e    state_q, state_d;
    op_class_e cls_q, cls_d;
    ctrl_out_t ctrl_q, ctrl_d;
    logic      halted_q, halted_d;
    logic      illegal_q, illegal_d;
    logic      mem_err_q, mem_err_d;
    logic      retire_c;
    logic      in_req_c;
    logic      expired;
    state_e    boundary_c;

    assign in_req_c   = (state_q == ST_FETCH) || (state_q == ST_MEM);
    assign boundary_c = run_i ? ST_FETCH : ST_IDLE;

    kgp_mem_wait_timer #(
        .TIMEOUT (MEM_TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_wait_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (!in_req_c),
        .en_i      (in_req_c && !mem_ack_i),
        .expired_o (expired)
    );

    // Next state, class latch, sticky flags, and strobes decoded from the next state.
    always_comb begin
        state_d   = state_q;
        cls_d     = cls_q;
        halted_d  = halted_q;
        illegal_d = illegal_q;
        mem_err_d = mem_err_q;
        retire_c  = 1'b0;
        ctrl_d    = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (run_i) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (mem_ack_i) begin
                    state_d = ST_FETCH_DONE;
                end else if (expired) begin
                    state_d   = ST_TRAP;
                    mem_err_d = 1'b1;
                end
            end
            ST_FETCH_DONE: state_d = ST_DECODE;
            ST_DECODE: begin
                cls_d = decode_op(op_i);
                case (cls_d)
                    CLS_HALT: begin
                        state_d  = ST_HALT;
                        halted_d = 1'b1;
                    end
                    CLS_ILL: begin
                        state_d   = ST_TRAP;
                        illegal_d = 1'b1;
                    end
                    default: state_d = ST_EXEC;
                endcase
            end
            ST_EXEC: begin
                case (cls_q)
                    CLS_RTYPE, CLS_ADDI: state_d = ST_WB;
                    CLS_LW, CLS_SW:      state_d = ST_MEM;
                    default: begin
                        state_d  = boundary_c;
                        retire_c = 1'b1;
                    end
                endcase
            end
            ST_MEM: begin
                // An acknowledge in the expiry cycle still completes the access.
                if (mem_ack_i) begin
                    if (cls_q == CLS_LW) begin
                        state_d = ST_WB;
                    end else begin
                        state_d  = boundary_c;
                        retire_c = 1'b1;
                    end
                end else if (expired) begin
                    state_d   = ST_TRAP;
                    mem_err_d = 1'b1;
                end
            end
            ST_WB: begin
                state_d  = boundary_c;
                retire_c = 1'b1;
            end
            ST_HALT, ST_TRAP: state_d = state_q;
            default: state_d = ST_IDLE;
        endcase

        case (state_d)
            ST_FETCH: begin
                ctrl_d.mem_rd   = 1'b1;
                ctrl_d.addr_sel = ADDR_SEL_PC;
                ctrl_d.busy     = 1'b1;
            end
            ST_FETCH_DONE: begin
                ctrl_d.ir_we  = 1'b1;
                ctrl_d.pc_we  = 1'b1;
                ctrl_d.pc_src = PC_SRC_SEQ;
                ctrl_d.busy   = 1'b1;
            end
            ST_DECODE: ctrl_d.busy = 1'b1;
            ST_EXEC: begin
                ctrl_d.busy = 1'b1;
                case (cls_d)
                    CLS_RTYPE: begin
                        ctrl_d.aluop   = ALUOP_FUNCT;
                        ctrl_d.alu_src = ALU_SRC_REG;
                    end
                    CLS_ADDI, CLS_LW, CLS_SW: begin
                        ctrl_d.aluop   = ALUOP_ADD;
                        ctrl_d.alu_src = ALU_SRC_IMM;
                    end
                    CLS_BR: begin
                        ctrl_d.aluop   = ALUOP_SUB;
                        ctrl_d.alu_src = ALU_SRC_REG;
                        ctrl_d.pc_src  = PC_SRC_BR;
                    end
                    CLS_J: begin
                        ctrl_d.pc_we  = 1'b1;
                        ctrl_d.pc_src = PC_SRC_JMP;
                    end
                    default: ctrl_d.busy = 1'b1;
                endcase
            end
            ST_MEM: begin
                ctrl_d.addr_sel = ADDR_SEL_ALU;
                ctrl_d.mem_rd   = (cls_d == CLS_LW);
                ctrl_d.mem_wr   = (cls_d == CLS_SW);
                ctrl_d.busy     = 1'b1;
            end
            ST_WB: begin
                ctrl_d.reg_we = 1'b1;
                ctrl_d.wb_sel = (cls_d == CLS_LW) ? WB_SEL_MEM : WB_SEL_ALU;
                ctrl_d.busy   = 1'b1;
            end
            default: ctrl_d.busy = 1'b0;
        endcase
    end

    // State, class, strobe and sticky-flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cls_q     <= CLS_NONE;
            ctrl_q    <= '0;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cls_q     <= cls_d;
            ctrl_q    <= ctrl_d;
            halted_q  <= halted_d;
            illegal_q <= illegal_d;
            mem_err_q <= mem_err_d;
        end
    end

    assign mem_rd_o   = ctrl_q.mem_rd;
    assign mem_wr_o   = ctrl_q.mem_wr;
    assign addr_sel_o = ctrl_q.addr_sel;
    assign ir_we_o    = ctrl_q.ir_we;
    // Branch flags are only valid during EXEC, so the taken qualifier joins here.
    assign pc_we_o    = ctrl_q.pc_we
                      | ((state_q == ST_EXEC) && (cls_q == CLS_BR) && br_taken_i);
    assign pc_src_o   = ctrl_q.pc_src;
    assign aluop_o    = ctrl_q.aluop;
    assign alu_src_o  = ctrl_q.alu_src;
    assign reg_we_o   = ctrl_q.reg_we;
    assign wb_sel_o   = ctrl_q.wb_sel;
    assign busy_o     = ctrl_q.busy;
    assign halted_o   = halted_q;
    assign illegal_o  = illegal_q;
    assign mem_err_o  = mem_err_q;

`ifdef KGP_PERF_CNT_EN
    logic [31:0] cyc_cnt_q, ret_cnt_q;

    // Busy-cycle and retired-instruction counters, wrapping at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_cnt_q <= '0;
            ret_cnt_q <= '0;
        end else begin
            if (ctrl_q.busy) cyc_cnt_q <= cyc_cnt_q + 32'd1;
            if (retire_c)    ret_cnt_q <= ret_cnt_q + 32'd1;
        end
    end

    assign cyc_cnt_o = cyc_cnt_q;
    assign ret_cnt_o = ret_cnt_q;
`else
    logic unused_retire;
    assign unused_retire = retire_c;
`endif

endmodule

// File: tb/tb_kgp_multicycle_ctrl.sv
// Directed bench for kgp_multicycle_ctrl (MEM_TIMEOUT = 4).
`timescale 1ns/1ps
module tb_kgp_multicycle_ctrl;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BR    = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_HALT  = 6'b111111;
    localparam logic [5:0] OP_BAD   = 6'b110011;

    // Output vector: {rd, wr, asel, irwe, pcwe, src[1:0], aluop[2:0], asrc, rwe, wbs, busy, halt, ill, merr}
    localparam logic [16:0] B_RD    = 17'h10000;
    localparam logic [16:0] B_WR    = 17'h08000;
    localparam logic [16:0] B_ASEL  = 17'h04000;
    localparam logic [16:0] B_IRWE  = 17'h02000;
    localparam logic [16:0] B_PCWE  = 17'h01000;
    localparam logic [16:0] SRC_BR  = 17'h00400;
    localparam logic [16:0] SRC_J   = 17'h00800;
    localparam logic [16:0] ALU_SUB = 17'h00080;
    localparam logic [16:0] ALU_FN  = 17'h00380;
    localparam logic [16:0] B_ASRC  = 17'h00040;
    localparam logic [16:0] B_RWE   = 17'h00020;
    localparam logic [16:0] B_WBS   = 17'h00010;
    localparam logic [16:0] B_BUSY  = 17'h00008;
    localparam logic [16:0] B_HALT  = 17'h00004;
    localparam logic [16:0] B_ILL   = 17'h00002;
    localparam logic [16:0] B_MERR  = 17'h00001;

    localparam logic [16:0] V_IDLE   = 17'h0;
    localparam logic [16:0] V_FETCH  = B_RD | B_BUSY;
    localparam logic [16:0] V_FD     = B_IRWE | B_PCWE | B_BUSY;
    localparam logic [16:0] V_DEC    = B_BUSY;
    localparam logic [16:0] V_EX_IMM = B_ASRC | B_BUSY;
    localparam logic [16:0] V_EX_R   = ALU_FN | B_BUSY;
    localparam logic [16:0] V_EX_BRT = B_PCWE | SRC_BR | ALU_SUB | B_BUSY;
    localparam logic [16:0] V_EX_BRN = SRC_BR | ALU_SUB | B_BUSY;
    localparam logic [16:0] V_EX_J   = B_PCWE | SRC_J | B_BUSY;
    localparam logic [16:0] V_MEM_LW = B_RD | B_ASEL | B_BUSY;
    localparam logic [16:0] V_MEM_SW = B_WR | B_ASEL | B_BUSY;
    localparam logic [16:0] V_WB_ALU = B_RWE | B_BUSY;
    localparam logic [16:0] V_WB_LW  = B_RWE | B_WBS | B_BUSY;

    typedef struct packed {
        logic        run;
        logic        ack;
        logic        br;
        logic [5:0]  op;
        logic [16:0] exp;
    } step_t;

    logic        clk, rst_n, run, br_taken, mem_ack;
    logic [5:0]  op;
    logic        mem_rd, mem_wr, addr_sel, ir_we, pc_we, alu_src, reg_we, wb_sel;
    logic        busy, halted, illegal, mem_err;
    logic [1:0]  pc_src;
    logic [2:0]  aluop;
    logic [16:0] obs;
`ifdef KGP_PERF_CNT_EN
    logic [31:0] cyc_cnt, ret_cnt;
`endif

    int checks = 0;
    int fails  = 0;

    kgp_multicycle_ctrl #(.MEM_TIMEOUT(4), .CNT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run_i      (run),
        .op_i       (op),
        .br_taken_i (br_taken),
        .mem_ack_i  (mem_ack),
        .mem_rd_o   (mem_rd),
        .mem_wr_o   (mem_wr),
        .addr_sel_o (addr_sel),
        .ir_we_o    (ir_we),
        .pc_we_o    (pc_we),
        .pc_src_o   (pc_src),
        .aluop_o    (aluop),
        .alu_src_o  (alu_src),
        .reg_we_o   (reg_we),
        .wb_sel_o   (wb_sel),
        .busy_o     (busy),
        .halted_o   (halted),
        .illegal_o  (illegal),
        .mem_err_o  (mem_err)
`ifdef KGP_PERF_CNT_EN
        ,
        .cyc_cnt_o  (cyc_cnt),
        .ret_cnt_o  (ret_cnt)
`endif
    );

    assign obs = {mem_rd, mem_wr, addr_sel, ir_we, pc_we, pc_src, aluop,
                  alu_src, reg_we, wb_sel, busy, halted, illegal, mem_err};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic step_t st(input logic r, input logic a, input logic b,
                                 input logic [5:0] o, input logic [16:0] e);
        step_t s;
        s.run = r; s.ack = a; s.br = b; s.op = o; s.exp = e;
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input step_t s);
        run = s.run; mem_ack = s.ack; br_taken = s.br; op = s.op;
        #1;
    endtask

    task automatic do_reset();
        run = 1'b0; mem_ack = 1'b0; br_taken = 1'b0;
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; run = 1'b1; mem_ack = 1'b1; br_taken = 1'b1; op = OP_ADDI;
        #12;
        checks++;
        if (obs !== V_IDLE) begin fails++; $display("FAIL reset_async: got %h want %h", obs, V_IDLE); end
        tick();
        checks++;
        if (obs !== V_IDLE) begin fails++; $display("FAIL reset_held: got %h want %h", obs, V_IDLE); end
        run = 1'b0; mem_ack = 1'b0; br_taken = 1'b0;
        rst_n = 1'b1;
        tick();
        checks++;
        if (obs !== V_IDLE) begin fails++; $display("FAIL reset_idle: got %h want %h", obs, V_IDLE); end
    endtask

    task automatic test_addi();
        step_t s[7];
        s[0] = st(1, 0, 0, OP_ADDI, V_IDLE);
        s[1] = st(1, 1, 0, OP_ADDI, V_FETCH);
        s[2] = st(1, 0, 0, OP_ADDI, V_FD);
        s[3] = st(1, 0, 0, OP_ADDI, V_DEC);
        s[4] = st(1, 0, 0, OP_ADDI, V_EX_IMM);
        s[5] = st(0, 0, 0, OP_ADDI, V_WB_ALU);
        s[6] = st(0, 0, 0, OP_ADDI, V_IDLE);
        for (int i = 0; i < 7; i++) begin
            apply(s[i]);
            checks++;
            if (obs !== s[i].exp) begin fails++; $display("FAIL addi cyc%0d: got %h want %h", i, obs, s[i].exp); end
            tick();
        end
    endtask

    task automatic test_lw_wait();
        step_t s[11];
        s[0]  = st(1, 0, 0, OP_LW, V_IDLE);
        s[1]  = st(1, 1, 0, OP_LW, V_FETCH);
        s[2]  = st(1, 0, 0, OP_LW, V_FD);
        s[3]  = st(1, 0, 0, OP_LW, V_DEC);
        s[4]  = st(1, 0, 0, OP_LW, V_EX_IMM);
        s[5]  = st(1, 0, 0, OP_LW, V_MEM_LW);
        s[6]  = st(1, 0, 0, OP_LW, V_MEM_LW);
        s[7]  = st(1, 0, 0, OP_LW, V_MEM_LW);
        s[8]  = st(1, 1, 0, OP_LW, V_MEM_LW);
        s[9]  = st(0, 0, 0, OP_LW, V_WB_LW);
        s[10] = st(0, 0, 0, OP_LW, V_IDLE);
        for (int i = 0; i < 11; i++) begin
            apply(s[i]);
            checks++;
            if (obs !== s[i].exp) begin fails++; $display("FAIL lw_wait cyc%0d: got %h want %h", i, obs, s[i].exp); end
            tick();
        end
    endtask

    task automatic test_sw_run_drop();
        step_t s[9];
        s[0] = st(1, 0, 0, OP_SW, V_IDLE);
        s[1] = st(1, 1, 0, OP_SW, V_FETCH);
        s[2] = st(1, 0, 0, OP_SW, V_FD);
        s[3] = st(1, 0, 0, OP_SW, V_DEC);
        s[4] = st(1, 0, 0, OP_SW, V_EX_IMM);
        s[5] = st(0, 0, 0, OP_SW, V_MEM_SW);
        s[6] = st(0, 1, 0, OP_SW, V_MEM_SW);
        s[7] = st(0, 0, 0, OP_SW, V_IDLE);
        s[8] = st(0, 1, 0, OP_SW, V_IDLE);
        for (int i = 0; i < 9; i++) begin
            apply(s[i]);
            checks++;
            if (obs !== s[i].exp) begin fails++; $display("FAIL sw_run_drop cyc%0d: got %h want %h", i, obs, s[i].exp); end
            tick();
        end
    endtask

    task automatic test_branch();
        step_t s[10];
        s[0] = st(1, 0, 0, OP_BR, V_IDLE);
        s[1] = st(1, 1, 0, OP_BR, V_FETCH);
        s[2] = st(1, 0, 0, OP_BR, V_FD);
        s[3] = st(1, 0, 0, OP_BR, V_DEC);
        s[4] = st(1, 0, 1, OP_BR, V_EX_BRT);
        s[5] = st(1, 1, 0, OP_BR, V_FETCH);
        s[6] = st(1, 0, 0, OP_BR, V_FD);
        s[7] = st(1, 0, 0, OP_BR, V_DEC);
        s[8] = st(0, 0, 0, OP_BR, V_EX_BRN);
        s[9] = st(0, 0, 1, OP_BR, V_IDLE);
        for (int i = 0; i < 10; i++) begin
            apply(s[i]);
            checks++;
            if (obs !== s[i].exp) begin fails++; $display("FAIL branch cyc%0d: got %h want %h", i, obs, s[i].exp); end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        step_t s[11];
        s[0]  = st(1, 0, 0, OP_RTYPE, V_IDLE);
        s[1]  = st(1, 1, 0, OP_RTYPE, V_FETCH);
        s[2]  = st(1, 0, 0, OP_RTYPE, V_FD);
        s[3]  = st(1, 0, 0, OP_RTYPE, V_DEC);
        s[4]  = st(1, 0, 0, OP_J,     V_EX_R);
        s[5]  = st(1, 1, 0, OP_J,     V_WB_ALU);
        s[6]  = st(1, 1, 0, OP_J,     V_FETCH);
        s[7]  = st(1, 0, 0, OP_J,     V_FD);
        s[8]  = st(1, 0, 0, OP_J,     V_DEC);
        s[9]  = st(0, 0, 0, OP_J,     V_EX_J);
        s[10] = st(0, 0, 0, OP_J,     V_IDLE);
        for (int i = 0; i < 11; i++) begin
            apply(s[i]);
            checks++;
            if (obs !== s[i].exp) begin fails++; $display("FAIL back_to_back cyc%0d: got %h want %h", i, obs, s[i].exp); end
            tick();
        end
    endtask

    task automatic test_illegal();
        step_t s[7];
        s[0] = st(1, 0, 0, OP_BAD,  V_IDLE);
        s[1] = st(1, 1, 0, OP_BAD,  V_FETCH);
        s[2] = st(1, 0, 0, OP_BAD,  V_FD);
        s[3] = st(1, 0, 0, OP_BAD,  V_DEC);
        s[4] = st(1, 1, 0, OP_ADDI, B_ILL);
        s[5] = st(1, 1, 1, OP_ADDI, B_ILL);
        s[6] = st(1, 1, 0, OP_ADDI, B_ILL);
        for (int i = 0; i < 7; i++) begin
            apply(s[i]);
            checks++;
            if (obs !== s[i].exp) begin fails++; $display("FAIL illegal cyc%0d: got %h want %h", i, obs, s[i].exp); end
            tick();
        end
        do_reset();
        checks++;
        if (obs !== V_IDLE) begin fails++; $display("FAIL illegal_cleared: got %h want %h", obs, V_IDLE); end
    endtask

    task automatic test_halt();
        step_t s[7];
        s[0] = st(1, 0, 0, OP_HALT, V_IDLE);
        s[1] = st(1, 1, 0, OP_HALT, V_FETCH);
        s[2] = st(1, 0, 0, OP_HALT, V_FD);
        s[3] = st(1, 0, 0, OP_HALT, V_DEC);
        s[4] = st(1, 1, 0, OP_ADDI, B_HALT);
        s[5] = st(1, 1, 0, OP_ADDI, B_HALT);
        s[6] = st(0, 0, 0, OP_ADDI, B_HALT);
        for (int i = 0; i < 7; i++) begin
            apply(s[i]);
            checks++;
            if (obs !== s[i].exp) begin fails++; $display("FAIL halt cyc%0d: got %h want %h", i, obs, s[i].exp); end
            tick();
        end
        do_reset();
    endtask

    task automatic test_timeout();
        step_t s[7];
        s[0] = st(1, 0, 0, OP_ADDI, V_IDLE);
        s[1] = st(1, 0, 0, OP_ADDI, V_FETCH);
        s[2] = st(1, 0, 0, OP_ADDI, V_FETCH);
        s[3] = st(1, 0, 0, OP_ADDI, V_FETCH);
        s[4] = st(1, 0, 0, OP_ADDI, V_FETCH);
        s[5] = st(1, 1, 0, OP_ADDI, B_MERR);
        s[6] = st(1, 1, 0, OP_ADDI, B_MERR);
        for (int i = 0; i < 7; i++) begin
            apply(s[i]);
            checks++;
            if (obs !== s[i].exp) begin fails++; $display("FAIL timeout cyc%0d: got %h want %h", i, obs, s[i].exp); end
            tick();
        end
        do_reset();
    endtask

    task automatic test_ack_at_limit();
        step_t s[10];
        s[0] = st(1, 0, 0, OP_ADDI, V_IDLE);
        s[1] = st(1, 0, 0, OP_ADDI, V_FETCH);
        s[2] = st(1, 0, 0, OP_ADDI, V_FETCH);
        s[3] = st(1, 0, 0, OP_ADDI, V_FETCH);
        s[4] = st(1, 1, 0, OP_ADDI, V_FETCH);
        s[5] = st(1, 0, 0, OP_ADDI, V_FD);
        s[6] = st(1, 0, 0, OP_ADDI, V_DEC);
        s[7] = st(1, 0, 0, OP_ADDI, V_EX_IMM);
        s[8] = st(0, 0, 0, OP_ADDI, V_WB_ALU);
        s[9] = st(0, 0, 0, OP_ADDI, V_IDLE);
        for (int i = 0; i < 10; i++) begin
            apply(s[i]);
            checks++;
            if (obs !== s[i].exp) begin fails++; $display("FAIL ack_at_limit cyc%0d: got %h want %h", i, obs, s[i].exp); end
            tick();
        end
    endtask

    task automatic test_reset_mid_exec();
        step_t s[5];
        s[0] = st(1, 0, 0, OP_ADDI, V_IDLE);
        s[1] = st(1, 1, 0, OP_ADDI, V_FETCH);
        s[2] = st(1, 0, 0, OP_ADDI, V_FD);
        s[3] = st(1, 0, 0, OP_ADDI, V_DEC);
        s[4] = st(1, 0, 0, OP_ADDI, V_EX_IMM);
        for (int i = 0; i < 5; i++) begin
            apply(s[i]);
            checks++;
            if (obs !== s[i].exp) begin fails++; $display("FAIL rst_mid_exec cyc%0d: got %h want %h", i, obs, s[i].exp); end
            if (i < 4) tick();
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== V_IDLE) begin fails++; $display("FAIL rst_mid_exec_async: got %h want %h", obs, V_IDLE); end
        run = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (obs !== V_IDLE) begin fails++; $display("FAIL rst_mid_exec_after: got %h want %h", obs, V_IDLE); end
    endtask

    initial begin
        rst_n = 1'b0; run = 1'b0; mem_ack = 1'b0; br_taken = 1'b0; op = '0;
        test_reset();
        test_addi();
        test_lw_wait();
        test_sw_run_drop();
        test_branch();
        test_back_to_back();
        test_illegal();
        test_halt();
        test_timeout();
        test_ack_at_limit();
        test_reset_mid_exec();
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
